param_seq_detector: RTL and testbench
=====================================

PARAM_SEQ_DETECTOR -- requirements
Module: param_seq_detector

Interface
REQ-001 SHALL have parameter DATA_W, default 3: symbol width in bits.
REQ-002 SHALL have parameter SEQ_LEN, default 8: pattern length in symbols (2..32).
REQ-003 SHALL have parameter OVERLAP, default 1: 1 = overlapping matches allowed, 0 = non-overlapping.
REQ-004 SHALL have parameter CNT_W, default 8: match counter width.
REQ-005 SHALL have parameter PATTERN_INIT, default {001,101,110,000,110,110,011,101} (first symbol in MS slot), width SEQ_LEN*DATA_W: pattern after reset.
REQ-006 SHALL have port clk  in  1  sole clock, rising edge.
REQ-007 SHALL have port rst_n  in  1  reset; one clock, reset is synchronous and active-low.
REQ-008 SHALL have port in_valid  in  1  in_data beat valid this cycle.
REQ-009 SHALL have port in_data  in  DATA_W  input symbol.
REQ-010 SHALL have port cfg_we  in  1  write one pattern slot.
REQ-011 SHALL have port cfg_idx  in  $clog2(SEQ_LEN)  slot index, 0 = first symbol of sequence.
REQ-012 SHALL have port cfg_sym  in  DATA_W  symbol to write.
REQ-013 SHALL have port cfg_care  in  1  1 = slot compared, 0 = slot is don't-care.
REQ-014 SHALL have port clear  in  1  clear history, counter and sticky flag.
REQ-015 SHALL have port match  out  1  one-cycle pulse per detected sequence.
REQ-016 SHALL have port match_sticky  out  1  set on any match, held until clear/reset.
REQ-017 SHALL have port match_count  out  CNT_W  number of matches, saturating.
REQ-018 SHALL have port fill  out  $clog2(SEQ_LEN+1)  valid symbols in history window, saturates at SEQ_LEN.

Function
REQ-019 SHALL hold a history window of the last SEQ_LEN accepted symbols; each accepted beat shifts in in_data as newest.
REQ-020 SHALL accept a beat only when in_valid=1 and clear=0 and cfg_we=0.
REQ-021 SHALL declare a hit when fill (including the accepted beat) reaches SEQ_LEN and every care slot i equals window symbol i (slot 0 vs oldest).
REQ-022 SHALL assert match exactly one cycle after the clock edge accepting the completing beat (registered, latency 1); no pulse on cycles without an accepted beat.
REQ-023 SHALL, with OVERLAP=1, keep fill at SEQ_LEN after a hit so the next beat can hit again.
REQ-024 SHALL, with OVERLAP=0, set fill to 0 on a hit so SEQ_LEN fresh beats are needed.
REQ-025 SHALL increment match_count on each hit, saturating at 2^CNT_W-1 (no wrap).
REQ-026 SHALL set match_sticky on each hit.
REQ-027 SHALL, on cfg_we=1, write cfg_sym and cfg_care to slot cfg_idx, set fill to 0, ignore in_valid that cycle; cfg_idx >= SEQ_LEN ignored (no write, no fill reset).
REQ-028 SHALL, on clear=1, set fill, match_count, match_sticky to 0 and drop any same-cycle beat; clear has priority over cfg_we; pattern unchanged.
REQ-029 SHALL treat an all-don't-care pattern as hit on every accepted beat once fill=SEQ_LEN.
REQ-030 SHALL not assert match for a hit whose completing beat was dropped by clear or cfg_we.

Reset
REQ-031 SHALL, on rst_n=0 at a clock edge, set match=0, match_sticky=0, match_count=0, fill=0, history to 0, pattern to PATTERN_INIT, all care bits to 1.
REQ-032 SHALL apply reset mid-sequence with no residual match pulse in the following cycle.

Structure
REQ-033 SHALL take a shared package seq_det_pkg holding default pattern constant and a function computing index/fill widths.
REQ-034 SHALL contain one sub-module seq_det_window: history shift register plus masked parallel comparator, outputting hit.
REQ-035 SHALL keep control (fill, counter, sticky, config writes) in the top module; no latches, all state on clk.

Verification
REQ-036 SHALL cover: default pattern 001,101,110,000,110,110,011,101 streamed back-to-back -> match=1 one cycle after 8th beat, match_count=1.
REQ-037 SHALL cover: OVERLAP=1, pattern 1,1,1 (SEQ_LEN=3, DATA_W=1), input five 1s -> three match pulses, count=3; OVERLAP=0 same input -> one pulse.
REQ-038 SHALL cover: in_valid gaps inside sequence (beats separated by idle cycles) -> single match, none on idle cycles.
REQ-039 SHALL cover: CNT_W=2, five matches -> match_count sticks at 3, match_sticky=1; then clear -> count=0, sticky=0, fill=0.
REQ-040 SHALL cover: cfg_we slot 3 care=0 then stream pattern with slot 3 = 111 -> match; cfg_we during stream -> fill=0, no match.
REQ-041 SHALL cover: rst_n=0 for one cycle after 7 correct beats, then 8th beat -> no match, fill=1.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants and width helpers for the parameterised sequence detector.
package seq_det_pkg;

    localparam int DEF_DATA_W  = 3;
    localparam int DEF_SEQ_LEN = 8;

    // First symbol of the sequence sits in the most-significant slot.
    localparam logic [DEF_SEQ_LEN*DEF_DATA_W-1:0] DEF_PATTERN = {
        3'b001, 3'b101, 3'b110, 3'b000, 3'b110, 3'b110, 3'b011, 3'b101
    };

    function automatic int idx_w(input int seq_len);
        return (seq_len <= 1) ? 1 : $clog2(seq_len);
    endfunction

    function automatic int fill_w(input int seq_len);
        return $clog2(seq_len + 1);
    endfunction

endpackage

// File: rtl/seq_det_window.sv
// History shift register with a masked parallel compare of the window that
// results from shifting in the current symbol.
module seq_det_window
    import seq_det_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SEQ_LEN = DEF_SEQ_LEN
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clr,
    input  logic                             shift_en,
    input  logic [DATA_W-1:0]                din,
    input  logic [SEQ_LEN-1:0][DATA_W-1:0]   pattern,
    input  logic [SEQ_LEN-1:0]               care,
    output logic                             hit
);

    // Slot 0 holds the oldest symbol, slot SEQ_LEN-1 the newest.
    logic [SEQ_LEN-1:0][DATA_W-1:0] hist_p0;
    logic [SEQ_LEN-1:0][DATA_W-1:0] win_nxt;

    always_comb begin
        win_nxt = '0;
        for (int i = 0; i < SEQ_LEN - 1; i++) begin
            win_nxt[i] = hist_p0[i+1];
        end
        win_nxt[SEQ_LEN-1] = din;
    end

    always_comb begin
        hit = 1'b1;
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (care[i] && (win_nxt[i] != pattern[i])) begin
                hit = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            hist_p0 <= '0;
        end else if (shift_en) begin
            hist_p0 <= win_nxt;
        end
    end

endmodule

// File: rtl/param_seq_detector.sv
// Streaming symbol-sequence detector with per-slot don't-care masking,
// saturating match counter and sticky flag.
module param_seq_detector
    import seq_det_pkg::*;
#(
    parameter int                            DATA_W       = DEF_DATA_W,
    parameter int                            SEQ_LEN      = DEF_SEQ_LEN,
    parameter int                            OVERLAP      = 1,
    parameter int                            CNT_W        = 8,
    parameter logic [SEQ_LEN*DATA_W-1:0]     PATTERN_INIT = DEF_PATTERN
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    input  logic [DATA_W-1:0]                in_data,
    input  logic                             cfg_we,
    input  logic [idx_w(SEQ_LEN)-1:0]        cfg_idx,
    input  logic [DATA_W-1:0]                cfg_sym,
    input  logic                             cfg_care,
    input  logic                             clear,
    output logic                             match,
    output logic                             match_sticky,
    output logic [CNT_W-1:0]                 match_count,
    output logic [fill_w(SEQ_LEN)-1:0]       fill
);

    localparam int                IDX_W   = idx_w(SEQ_LEN);
    localparam int                FILL_W  = fill_w(SEQ_LEN);
    localparam logic [FILL_W-1:0] FULL    = FILL_W'(SEQ_LEN);
    localparam logic [IDX_W:0]    SLOTS   = (IDX_W+1)'(SEQ_LEN);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] v);
        return (v == FULL) ? v : v + 1'b1;
    endfunction

    logic [SEQ_LEN-1:0][DATA_W-1:0] pat_q;
    logic [SEQ_LEN-1:0]             care_q;
    logic [FILL_W-1:0]              fill_q;
    logic [FILL_W-1:0]              fill_nxt;
    logic [CNT_W-1:0]               cnt_q;
    logic                           sticky_q;
    logic                           match_p1;
    logic                           accept;
    logic                           cfg_ok;
    logic                           win_hit;
    logic                           hit_p0;

    // Config writes and clear both swallow any beat presented in the same cycle.
    assign accept   = in_valid && !clear && !cfg_we;
    assign cfg_ok   = cfg_we && !clear && ({1'b0, cfg_idx} < SLOTS);
    assign fill_nxt = fill_inc(fill_q);
    assign hit_p0   = accept && (fill_nxt == FULL) && win_hit;

    seq_det_window #(
        .DATA_W  (DATA_W),
        .SEQ_LEN (SEQ_LEN)
    ) u_window (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clear),
        .shift_en (accept),
        .din      (in_data),
        .pattern  (pat_q),
        .care     (care_q),
        .hit      (win_hit)
    );

    // ---- stage p0 -> p1: control state and registered match pulse ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            match_p1 <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            fill_q   <= '0;
            care_q   <= '1;
            for (int i = 0; i < SEQ_LEN; i++) begin
                pat_q[i] <= PATTERN_INIT[(SEQ_LEN-1-i)*DATA_W +: DATA_W];
            end
        end else begin
            match_p1 <= hit_p0;
            if (clear) begin
                fill_q   <= '0;
                cnt_q    <= '0;
                sticky_q <= 1'b0;
            end else if (cfg_we) begin
                if (cfg_ok) begin
                    pat_q[cfg_idx]  <= cfg_sym;
                    care_q[cfg_idx] <= cfg_care;
                    fill_q          <= '0;
                end
            end else if (accept) begin
                if (hit_p0) begin
                    fill_q   <= (OVERLAP != 0) ? fill_nxt : '0;
                    cnt_q    <= sat_inc(cnt_q);
                    sticky_q <= 1'b1;
                end else begin
                    fill_q <= fill_nxt;
                end
            end
        end
    end

    assign match        = match_p1;
    assign match_sticky = sticky_q;
    assign match_count  = cnt_q;
    assign fill         = fill_q;

endmodule

// File: tb/tb_param_seq_detector.sv
// Directed bench: default 8x3 detector plus three 3x1 variants sharing one stimulus.
module tb_param_seq_detector;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: default parameters
    logic       a_in_valid, a_cfg_we, a_cfg_care, a_clear;
    logic [2:0] a_in_data, a_cfg_idx, a_cfg_sym;
    logic       a_match, a_sticky;
    logic [7:0] a_count;
    logic [3:0] a_fill;

    // Instances B (overlap), C (non-overlap), D (overlap, 2-bit counter)
    logic       b_in_valid, b_cfg_we, b_cfg_care, b_clear;
    logic [0:0] b_in_data, b_cfg_sym;
    logic [1:0] b_cfg_idx;
    logic       b_match, b_sticky, c_match, c_sticky, d_match, d_sticky;
    logic [7:0] b_count, c_count;
    logic [1:0] d_count;
    logic [1:0] b_fill, c_fill, d_fill;

    param_seq_detector u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_data(a_in_data),
        .cfg_we(a_cfg_we), .cfg_idx(a_cfg_idx), .cfg_sym(a_cfg_sym), .cfg_care(a_cfg_care),
        .clear(a_clear), .match(a_match), .match_sticky(a_sticky),
        .match_count(a_count), .fill(a_fill)
    );

    param_seq_detector #(.DATA_W(1), .SEQ_LEN(3), .OVERLAP(1), .CNT_W(8), .PATTERN_INIT(3'b111)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_data(b_in_data),
        .cfg_we(b_cfg_we), .cfg_idx(b_cfg_idx), .cfg_sym(b_cfg_sym), .cfg_care(b_cfg_care),
        .clear(b_clear), .match(b_match), .match_sticky(b_sticky),
        .match_count(b_count), .fill(b_fill)
    );

    param_seq_detector #(.DATA_W(1), .SEQ_LEN(3), .OVERLAP(0), .CNT_W(8), .PATTERN_INIT(3'b111)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_data(b_in_data),
        .cfg_we(b_cfg_we), .cfg_idx(b_cfg_idx), .cfg_sym(b_cfg_sym), .cfg_care(b_cfg_care),
        .clear(b_clear), .match(c_match), .match_sticky(c_sticky),
        .match_count(c_count), .fill(c_fill)
    );

    param_seq_detector #(.DATA_W(1), .SEQ_LEN(3), .OVERLAP(1), .CNT_W(2), .PATTERN_INIT(3'b111)) u_d (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_data(b_in_data),
        .cfg_we(b_cfg_we), .cfg_idx(b_cfg_idx), .cfg_sym(b_cfg_sym), .cfg_care(b_cfg_care),
        .clear(b_clear), .match(d_match), .match_sticky(d_sticky),
        .match_count(d_count), .fill(d_fill)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_beat(input logic [2:0] sym);
        a_in_valid = 1'b1;
        a_in_data  = sym;
        tick();
        a_in_valid = 1'b0;
    endtask

    task automatic b_beat(input logic sym);
        b_in_valid   = 1'b1;
        b_in_data[0] = sym;
        tick();
        b_in_valid   = 1'b0;
    endtask

    task automatic b_cfg(input logic [1:0] idx, input logic sym, input logic care);
        b_cfg_we     = 1'b1;
        b_cfg_idx    = idx;
        b_cfg_sym[0] = sym;
        b_cfg_care   = care;
        tick();
        b_cfg_we     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    logic [2:0] pat_def [8] = '{3'd1, 3'd5, 3'd6, 3'd0, 3'd6, 3'd6, 3'd3, 3'd5};
    logic [2:0] pat_dc3 [8] = '{3'd1, 3'd5, 3'd6, 3'd7, 3'd6, 3'd6, 3'd3, 3'd5};
    logic       exp_b   [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       exp_c   [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [0:0] dc_in   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic       exp_dc  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        rst_n = 1'b0;
        a_in_valid = 0; a_in_data = 0; a_cfg_we = 0; a_cfg_idx = 0; a_cfg_sym = 0;
        a_cfg_care = 0; a_clear = 0;
        b_in_valid = 0; b_in_data = 0; b_cfg_we = 0; b_cfg_idx = 0; b_cfg_sym = 0;
        b_cfg_care = 0; b_clear = 0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_a_match", a_match, 0);
        chk("rst_a_count", a_count, 0);
        chk("rst_a_fill", a_fill, 0);
        chk("rst_a_sticky", a_sticky, 0);
        chk("rst_d_count", d_count, 0);

        // Default pattern back-to-back
        for (int k = 0; k < 8; k++) begin
            a_beat(pat_def[k]);
            chk($sformatf("b2b_match_%0d", k), a_match, (k == 7) ? 1 : 0);
        end
        chk("b2b_count", a_count, 1);
        chk("b2b_fill", a_fill, 8);
        chk("b2b_sticky", a_sticky, 1);
        tick();
        chk("b2b_idle_match", a_match, 0);

        // Clear beats cfg_we: slot 0 write must not land
        a_clear = 1; a_cfg_we = 1; a_cfg_idx = 0; a_cfg_sym = 7; a_cfg_care = 1;
        a_in_valid = 1; a_in_data = 1;
        tick();
        a_clear = 0; a_cfg_we = 0; a_in_valid = 0;
        chk("clr_count", a_count, 0);
        chk("clr_sticky", a_sticky, 0);
        chk("clr_fill", a_fill, 0);

        // Idle gaps between beats
        for (int k = 0; k < 8; k++) begin
            a_beat(pat_def[k]);
            chk($sformatf("gap_beat_%0d", k), a_match, (k == 7) ? 1 : 0);
            tick();
            chk($sformatf("gap_idle_%0d", k), a_match, 0);
        end
        chk("gap_count", a_count, 1);

        // Slot 3 don't-care, beat during cfg_we is ignored
        a_cfg_we = 1; a_cfg_idx = 3; a_cfg_sym = 0; a_cfg_care = 0;
        a_in_valid = 1; a_in_data = 5;
        tick();
        a_cfg_we = 0; a_in_valid = 0;
        chk("cfg_fill0", a_fill, 0);
        for (int k = 0; k < 8; k++) begin
            a_beat(pat_dc3[k]);
            chk($sformatf("dc3_match_%0d", k), a_match, (k == 7) ? 1 : 0);
        end
        chk("dc3_count", a_count, 2);
        for (int k = 0; k < 4; k++) begin
            a_beat(pat_def[k]);
            chk($sformatf("pre_cfg_match_%0d", k), a_match, 0);
        end
        a_cfg_we = 1; a_cfg_idx = 3; a_cfg_sym = 0; a_cfg_care = 0;
        a_in_valid = 1; a_in_data = pat_def[4];
        tick();
        a_cfg_we = 0; a_in_valid = 0;
        chk("mid_cfg_fill", a_fill, 0);
        chk("mid_cfg_match", a_match, 0);
        for (int k = 4; k < 8; k++) begin
            a_beat(pat_def[k]);
            chk($sformatf("post_cfg_match_%0d", k), a_match, 0);
        end
        chk("post_cfg_fill", a_fill, 4);

        // Reset after 7 correct beats
        a_clear = 1;
        tick();
        a_clear = 0;
        for (int k = 0; k < 7; k++) a_beat(pat_def[k]);
        chk("pre_rst_fill", a_fill, 7);
        rst_n = 0; a_in_valid = 1; a_in_data = pat_def[7];
        tick();
        rst_n = 1; a_in_valid = 0;
        chk("rst_mid_match", a_match, 0);
        chk("rst_mid_fill", a_fill, 0);
        tick();
        chk("rst_residual_match", a_match, 0);
        a_beat(pat_def[7]);
        chk("rst_8th_match", a_match, 0);
        chk("rst_8th_fill", a_fill, 1);
        // Pattern and care restored: full default pattern now matches
        for (int k = 0; k < 8; k++) begin
            a_beat(pat_def[k]);
            chk($sformatf("restore_match_%0d", k), a_match, (k == 7) ? 1 : 0);
        end

        // 1-bit detectors: overlap vs non-overlap vs saturating counter
        for (int k = 0; k < 7; k++) begin
            b_beat(1'b1);
            chk($sformatf("ovl_b_match_%0d", k), b_match, exp_b[k]);
            chk($sformatf("ovl_c_match_%0d", k), c_match, exp_c[k]);
            chk($sformatf("ovl_d_match_%0d", k), d_match, exp_b[k]);
            if (k == 4) begin
                chk("five_b_count", b_count, 3);
                chk("five_c_count", c_count, 1);
            end
        end
        chk("seven_b_count", b_count, 5);
        chk("seven_c_count", c_count, 2);
        chk("sat_d_count", d_count, 3);
        chk("sat_d_sticky", d_sticky, 1);
        chk("seven_c_fill", c_fill, 1);
        chk("seven_b_fill", b_fill, 3);
        b_beat(1'b0);
        chk("zero_b_match", b_match, 0);
        chk("zero_b_fill", b_fill, 3);
        b_cfg(2'd3, 1'b0, 1'b0);
        chk("badidx_b_fill", b_fill, 3);
        b_clear = 1;
        tick();
        b_clear = 0;
        chk("clr_d_count", d_count, 0);
        chk("clr_d_sticky", d_sticky, 0);
        chk("clr_d_fill", d_fill, 0);

        // All-don't-care pattern hits every beat once full
        b_cfg(2'd0, 1'b0, 1'b0);
        b_cfg(2'd1, 1'b0, 1'b0);
        b_cfg(2'd2, 1'b0, 1'b0);
        chk("dc_b_fill", b_fill, 0);
        for (int k = 0; k < 4; k++) begin
            b_beat(dc_in[k][0]);
            chk($sformatf("alldc_b_match_%0d", k), b_match, exp_dc[k]);
        end
        chk("alldc_b_count", b_count, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
